refcpu_mem_arbiter: RTL and testbench

//  Shares one memory port between the refcpu instruction bus (i*) and data bus (d*).

---
 rtl/refcpu_mem_arbiter.sv | 94 +++++++++
 tb/tb_refcpu_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/refcpu_mem_arbiter.sv
// refcpu_mem_arbiter: shares one memory port between the refcpu ibus and dbus, one transaction at a time
//   clk, reset                          clock, synchronous active-high reset
//   i_valid/i_addr -> i_addr_ok/i_data_ok/i_data                       instruction bus
//   d_valid/d_addr/d_size/d_strobe/d_wdata -> d_addr_ok/d_data_ok/d_data   data bus
//   m_valid/m_addr/m_size/m_strobe/m_wdata <- m_addr_ok/m_data_ok/m_data  memory port
//   bus_err                             sticky watchdog error, cleared only by reset
module refcpu_mem_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [3:0]  d_strobe,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_data,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [2:0]  m_size,
  output logic [3:0]  m_strobe,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_data,
  output logic        bus_err
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX = '1;
  logic [1:0] state, nxt;
  logic own_d, last_d, err_q, req_v, in_addr, in_data, go, a_ok, both_ok, fin, busy, grant, grant_d;
  logic [TW-1:0] timer;
  assign req_v   = own_d ? d_valid : i_valid;
  assign busy    = state == S_ADDR || state == S_DATA;
  assign in_addr = state == S_ADDR && !reset;
  assign in_data = state == S_DATA && !reset;
  assign go      = in_addr && req_v;
  assign a_ok    = go && m_addr_ok;
  assign both_ok = a_ok && m_data_ok;
  assign grant   = state == S_IDLE && (i_valid || d_valid);
  // alternate only under contention: D wins a tie unless it won the previous grant
  assign grant_d = d_valid && (!i_valid || !last_d);
  // an owner that drops valid before addr_ok aborts without touching memory
  assign fin     = state == S_ADDR ? (!req_v || (m_addr_ok && m_data_ok)) : m_data_ok;
  always_comb
    nxt = state == S_IDLE ? (grant ? S_ADDR : S_IDLE) :
          state == S_ERR  ? S_ERR :
          fin             ? S_IDLE :
          timer == T_LAST ? S_ERR :
          (state == S_ADDR && m_addr_ok) ? S_DATA : state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      own_d  <= 1'b0;
      last_d <= 1'b0;
      timer  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= nxt;
      if (grant) begin
        own_d  <= grant_d;
        last_d <= grant_d;
        timer  <= '0;
      end else if (busy) begin
        timer <= timer == T_MAX ? timer : timer + 1'b1;
      end
      if (busy && nxt == S_ERR) err_q <= 1'b1;
    end
  end
  assign m_valid   = go;
  assign m_addr    = in_addr ? (own_d ? d_addr : i_addr) : 32'd0;
  assign m_size    = in_addr ? (own_d ? d_size : 3'b010) : 3'd0;
  assign m_strobe  = in_addr && own_d ? d_strobe : 4'd0;
  assign m_wdata   = in_addr && own_d ? d_wdata : 32'd0;
  assign i_addr_ok = a_ok && !own_d;
  assign d_addr_ok = a_ok && own_d;
  assign i_data_ok = (both_ok || (in_data && m_data_ok)) && !own_d;
  assign d_data_ok = (both_ok || (in_data && m_data_ok)) && own_d;
  assign i_data    = (both_ok || in_data) && !own_d ? m_data : 32'd0;
  assign d_data    = (both_ok || in_data) && own_d ? m_data : 32'd0;
  assign bus_err   = err_q && !reset;
endmodule

// File: tb/tb_refcpu_mem_arbiter.sv
// tb_refcpu_mem_arbiter: directed checks of arbitration, pass-through, abort, watchdog and reset
module tb_refcpu_mem_arbiter;
  logic clk = 0, reset = 1;
  logic i_valid = 0, d_valid = 0, m_addr_ok = 0, m_data_ok = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_data = 0;
  logic [2:0] d_size = 0;
  logic [3:0] d_strobe = 0;
  logic i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_valid, bus_err;
  logic [31:0] i_data, d_data, m_addr, m_wdata;
  logic [2:0] m_size;
  logic [3:0] m_strobe;
  int total = 0, bad = 0;
  refcpu_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_data(d_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_data(m_data), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    i_valid = 1;
    d_valid = 1;
    tick;
    #1;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_i_addr_ok", 32'(i_addr_ok), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    tick;
    reset = 0;
    d_valid = 0;
    i_addr = 32'hBFC00000;
    #1;
    chk("t1_idle_m_valid", 32'(m_valid), 0);
    tick;
    chk("t1_m_valid", 32'(m_valid), 1);
    chk("t1_m_addr", m_addr, 32'hBFC00000);
    chk("t1_m_size", 32'(m_size), 2);
    chk("t1_m_strobe", 32'(m_strobe), 0);
    chk("t1_addr_ok_wait", 32'(i_addr_ok), 0);
    tick;
    m_addr_ok = 1;
    #1;
    chk("t1_i_addr_ok", 32'(i_addr_ok), 1);
    chk("t1_d_addr_ok", 32'(d_addr_ok), 0);
    tick;
    m_addr_ok = 0;
    i_valid = 0;
    #1;
    chk("t1_data_m_valid", 32'(m_valid), 0);
    chk("t1_data_ok_wait", 32'(i_data_ok), 0);
    tick;
    m_data_ok = 1;
    m_data = 32'h24020001;
    #1;
    chk("t1_i_data_ok", 32'(i_data_ok), 1);
    chk("t1_i_data", i_data, 32'h24020001);
    chk("t1_d_data_ok", 32'(d_data_ok), 0);
    chk("t1_d_data", d_data, 0);
    tick;
    m_data_ok = 0;
    #1;
    chk("t1_done_i_data_ok", 32'(i_data_ok), 0);
    reset = 1;
    tick;
    reset = 0;
    i_valid = 1;
    d_valid = 1;
    i_addr = 32'h1000;
    d_addr = 32'h2000;
    d_size = 3'b010;
    tick;
    chk("t2_first_d", m_addr, 32'h2000);
    m_addr_ok = 1;
    m_data_ok = 1;
    m_data = 32'h11112222;
    #1;
    chk("t4_d_addr_ok", 32'(d_addr_ok), 1);
    chk("t4_d_data_ok", 32'(d_data_ok), 1);
    chk("t4_d_data", d_data, 32'h11112222);
    chk("t4_i_addr_ok", 32'(i_addr_ok), 0);
    tick;
    m_addr_ok = 0;
    m_data_ok = 0;
    #1;
    chk("t4_idle_m_valid", 32'(m_valid), 0);
    tick;
    chk("t2_then_i", m_addr, 32'h1000);
    m_addr_ok = 1;
    #1;
    chk("t2_i_addr_ok", 32'(i_addr_ok), 1);
    tick;
    m_addr_ok = 0;
    m_data_ok = 1;
    m_data = 32'h33334444;
    #1;
    chk("t2_i_data", i_data, 32'h33334444);
    chk("t2_d_data_ns", d_data, 0);
    tick;
    m_data_ok = 0;
    tick;
    chk("t2_then_d", m_addr, 32'h2000);
    i_valid = 0;
    d_valid = 0;
    #1;
    chk("abort_m_valid", 32'(m_valid), 0);
    tick;
    tick;
    chk("abort_idle", 32'(m_valid), 0);
    d_valid = 1;
    d_addr = 32'h80000010;
    d_size = 3'b001;
    d_strobe = 4'b0011;
    d_wdata = 32'hDEADBEEF;
    tick;
    chk("t3_m_addr", m_addr, 32'h80000010);
    chk("t3_m_strobe", 32'(m_strobe), 32'h3);
    chk("t3_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("t3_m_size", 32'(m_size), 1);
    m_addr_ok = 1;
    #1;
    chk("t3_d_addr_ok", 32'(d_addr_ok), 1);
    tick;
    d_valid = 0;
    m_addr_ok = 0;
    m_data_ok = 1;
    #1;
    chk("t3_d_data_ok", 32'(d_data_ok), 1);
    tick;
    m_data_ok = 0;
    d_valid = 1;
    d_addr = 32'h40;
    d_strobe = 0;
    tick;
    for (int k = 1; k < 8; k++) begin
      tick;
      chk($sformatf("t5_no_err_%0d", k), 32'(bus_err), 0);
    end
    tick;
    chk("t5_bus_err", 32'(bus_err), 1);
    chk("t5_err_m_valid", 32'(m_valid), 0);
    m_addr_ok = 1;
    tick;
    tick;
    chk("t5_err_sticky", 32'(bus_err), 1);
    chk("t5_err_addr_ok", 32'(d_addr_ok), 0);
    m_addr_ok = 0;
    d_valid = 0;
    reset = 1;
    tick;
    reset = 0;
    #1;
    chk("t5_err_cleared", 32'(bus_err), 0);
    i_valid = 1;
    i_addr = 32'h500;
    tick;
    m_addr_ok = 1;
    tick;
    m_addr_ok = 0;
    i_valid = 0;
    reset = 1;
    m_data_ok = 1;
    m_data = 32'h77;
    #1;
    chk("t6_rst_data_ok", 32'(i_data_ok), 0);
    chk("t6_rst_data", i_data, 0);
    tick;
    reset = 0;
    #1;
    chk("t6_late_data_ok", 32'(i_data_ok), 0);
    chk("t6_idle_m_valid", 32'(m_valid), 0);
    tick;
    m_data_ok = 0;
    i_valid = 1;
    i_addr = 32'h600;
    tick;
    chk("t6_fresh_addr", m_addr, 32'h600);
    m_addr_ok = 1;
    m_data_ok = 1;
    m_data = 32'h99;
    #1;
    chk("t6_fresh_data_ok", 32'(i_data_ok), 1);
    chk("t6_fresh_data", i_data, 32'h99);
    tick;
    m_addr_ok = 0;
    m_data_ok = 0;
    i_valid = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
